// File: rtl/rr_enc_arbiter.sv
// rr_enc_arbiter: round-robin arbiter for NREQ requesters with one-hot and
// binary-encoded registered grant. A grant is held until the owner drops its
// request or the resource pulses done; the search pointer then advances past
// the released owner.
// Optional feature macro: HOLD_TIMEOUT_EN -- forcibly releases a grant held
// for MAX_HOLD cycles and pulses timeout for one cycle.
module rr_enc_arbiter #(
  parameter int unsigned NREQ     = 8,
  parameter int unsigned IDXW     = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  if (NREQ != (1 << IDXW) || MAX_HOLD < 2) begin : g_param_check
    $error("rr_enc_arbiter: unsupported parameter combination");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic            found;
  logic [IDXW-1:0] winner;
  logic            release_c;
  logic [IDXW-1:0] ptr_next_c;

`ifdef HOLD_TIMEOUT_EN
  localparam int unsigned CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [CW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;
`endif

  // Rotating priority search: first active request at or after ptr, wrapping.
  always_comb begin
    int unsigned pos;
    logic [IDXW-1:0] cand;
    found  = 1'b0;
    winner = '0;
    pos    = 0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos  = (int'(ptr_q) + k) % NREQ;
      cand = IDXW'(pos);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Release conditions and the pointer value that skips past the current owner.
  always_comb begin
    release_c  = done | ~req[idx_q];
    ptr_next_c = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
  end

  // Next-state and registered-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef HOLD_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << winner;
          idx_d   = winner;
`ifdef HOLD_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next_c;
`ifdef HOLD_TIMEOUT_EN
        end else if (hold_q == CW'(MAX_HOLD - 1)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = ptr_next_c;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef HOLD_TIMEOUT_EN
  // Hold counter and one-cycle timeout pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_enc_arbiter.sv
// Self-checking bench for rr_enc_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
// Define HOLD_TIMEOUT_EN for both files to exercise the forced-release path.
module tb_rr_enc_arbiter;

  localparam int NREQ     = 8;
  localparam int IDXW     = 3;
  localparam int MAX_HOLD = 16;
`ifdef HOLD_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            timeout;

  int n_cmp;
  int n_err;

  // Reference model: who owns the resource, where the search starts next,
  // how long the owner has held it, and whether a forced release just happened.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_to;

  rr_enc_arbiter #(
    .NREQ     (NREQ),
    .IDXW     (IDXW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic d);
    m_to = 1'b0;
    if (!m_busy) begin
      if (r != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (r[c]) begin
            m_owner = c;
            break;
          end
        end
        m_busy = 1'b1;
        m_hold = 0;
      end
    end else if (d || !r[m_owner]) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % NREQ;
    end else if (TIMEOUT_ON && m_hold == MAX_HOLD - 1) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % NREQ;
      m_to   = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] one;
    one = 1;
    return m_busy ? (one << m_owner) : '0;
  endfunction

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step(req, done);
    #1;
  endtask

  // Asynchronous reset pulse entirely between clock edges.
  task automatic do_reset();
    req   = '0;
    done  = 1'b0;
    #1;
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (gnt !== 8'h00) begin
      n_err++;
      $display("FAIL reset_gnt: got %h required 00", gnt);
    end
    n_cmp++;
    if (gnt_idx !== 3'd0) begin
      n_err++;
      $display("FAIL reset_idx: got %0d required 0", gnt_idx);
    end
    n_cmp++;
    if (gnt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b required 0", gnt_valid);
    end
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_timeout: got %b required 0", timeout);
    end
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req = 8'h08;
    tick();
    n_cmp++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'h08, 3'd3, 1'b1}) begin
      n_err++;
      $display("FAIL single_grant: got gnt=%h idx=%0d v=%b required gnt=08 idx=3 v=1",
               gnt, gnt_idx, gnt_valid);
    end
    req = 8'h00;
    tick();
    n_cmp++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'h00, 3'd3, 1'b0}) begin
      n_err++;
      $display("FAIL single_release: got gnt=%h idx=%0d v=%b required gnt=00 idx=3 v=0",
               gnt, gnt_idx, gnt_valid);
    end
    req = 8'hFF;
    tick();
    n_cmp++;
    if (gnt !== 8'h10) begin
      n_err++;
      $display("FAIL single_ptr_advance: got gnt=%h required 10", gnt);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    tick();
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] one;
    one = 1;
    do_reset();
    req = 8'hFF;
    for (int i = 0; i <= NREQ; i++) begin
      tick();
      n_cmp++;
      if ({gnt, gnt_idx} !== {one << (i % NREQ), 3'(i % NREQ)}) begin
        n_err++;
        $display("FAIL rotation_grant[%0d]: got gnt=%h idx=%0d required gnt=%h idx=%0d",
                 i, gnt, gnt_idx, one << (i % NREQ), i % NREQ);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_cmp++;
      if ({gnt, gnt_valid} !== {8'h00, 1'b0}) begin
        n_err++;
        $display("FAIL rotation_bubble[%0d]: got gnt=%h v=%b required gnt=00 v=0",
                 i, gnt, gnt_valid);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_done_with_req();
    do_reset();
    req = 8'h20;
    tick();
    n_cmp++;
    if (gnt !== 8'h20) begin
      n_err++;
      $display("FAIL dwr_first: got gnt=%h required 20", gnt);
    end
    req  = 8'h21;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    n_cmp++;
    if ({gnt, gnt_idx} !== {8'h01, 3'd0}) begin
      n_err++;
      $display("FAIL dwr_fair: got gnt=%h idx=%0d required gnt=01 idx=0", gnt, gnt_idx);
    end
    req = 8'h20;
    tick();
    tick();
    n_cmp++;
    if ({gnt, gnt_idx} !== {8'h20, 3'd5}) begin
      n_err++;
      $display("FAIL dwr_regrant: got gnt=%h idx=%0d required gnt=20 idx=5", gnt, gnt_idx);
    end
    req = '0;
    tick();
  endtask

  task automatic test_hold();
`ifdef HOLD_TIMEOUT_EN
    int held;
    bit seen;
    do_reset();
    req  = 8'h04;
    held = 0;
    seen = 1'b0;
    tick();
    for (int c = 0; c < 3 * MAX_HOLD && !seen; c++) begin
      if (gnt == 8'h04 && !timeout) begin
        held++;
        tick();
      end else begin
        seen = 1'b1;
      end
    end
    n_cmp++;
    if (held !== MAX_HOLD) begin
      n_err++;
      $display("FAIL hold_duration: got %0d cycles required %0d", held, MAX_HOLD);
    end
    n_cmp++;
    if ({gnt, timeout} !== {8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL hold_timeout_pulse: got gnt=%h to=%b required gnt=00 to=1", gnt, timeout);
    end
    tick();
    n_cmp++;
    if ({gnt, timeout} !== {8'h04, 1'b0}) begin
      n_err++;
      $display("FAIL hold_regrant: got gnt=%h to=%b required gnt=04 to=0", gnt, timeout);
    end
    // Owner releases on exactly the cycle the counter would have expired.
    repeat (MAX_HOLD - 1) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_cmp++;
    if ({gnt, timeout} !== {8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL hold_precedence: got gnt=%h to=%b required gnt=00 to=0", gnt, timeout);
    end
    req = '0;
    tick();
`else
    int ok;
    do_reset();
    req = 8'h04;
    ok  = 0;
    tick();
    for (int c = 0; c < 3 * MAX_HOLD; c++) begin
      if (gnt == 8'h04 && !timeout) ok++;
      tick();
    end
    n_cmp++;
    if (ok !== 3 * MAX_HOLD) begin
      n_err++;
      $display("FAIL hold_indefinite: got %0d held cycles required %0d", ok, 3 * MAX_HOLD);
    end
    req = '0;
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h40;
    tick();
    n_cmp++;
    if (gnt !== 8'h40) begin
      n_err++;
      $display("FAIL midrst_pre: got gnt=%h required 40", gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_async: got gnt=%h idx=%0d v=%b to=%b required all 0",
               gnt, gnt_idx, gnt_valid, timeout);
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    req   = 8'hC0;
    tick();
    n_cmp++;
    if ({gnt, gnt_idx} !== {8'h40, 3'd6}) begin
      n_err++;
      $display("FAIL midrst_first: got gnt=%h idx=%0d required gnt=40 idx=6", gnt, gnt_idx);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) < 3) req = 8'($urandom) & 8'($urandom);
      done = ($urandom_range(0, 9) < 2);
      tick();
      n_cmp++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !==
          {model_gnt(), 3'(m_owner), m_busy, m_to}) begin
        n_err++;
        $display("FAIL random[%0d]: got gnt=%h idx=%0d v=%b to=%b required gnt=%h idx=%0d v=%b to=%b",
                 c, gnt, gnt_idx, gnt_valid, timeout, model_gnt(), m_owner, m_busy, m_to);
      end
      n_cmp++;
      if ($onehot0(gnt) !== 1'b1) begin
        n_err++;
        $display("FAIL random_onehot[%0d]: got gnt=%h required one-hot or zero", c, gnt);
      end
    end
    req  = '0;
    done = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_rotation();
    test_done_with_req();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
